sam_ctl_gen2: RTL and testbench
===============================

// Module: sam_ctl_gen2
// PURPOSE
//   Second-generation SAM: parametrised clock, register and address controller for the CoCo core.
//   Generates E/Q CPU clocks with a selectable MPU rate, decodes chip selects, and holds the
//   FFC0-FFDF set/clear control bank. Adds a VDG display-address counter with per-mode row
//   repeat, and multiplexes video/CPU addresses onto the RAM bus.
// PARAMETERS
//   SLOW_DIV   16  clk cycles per E period at slow rate (even, multiple of 4)
//   FAST_DIV    8  clk cycles per E period at fast rate (even, multiple of 4)
//   OFFSET_W    7  display offset width F (512-byte pages)
// PORTS
//   clk         in   1   system clock
//   reset       in   1   asynchronous, active-high reset
//   cpu_addr    in  16   CPU address
//   cpu_rw      in   1   CPU R/W (1 = read)
//   vdg_da0     in   1   one-clk pulse per VDG byte fetch
//   vdg_hs_n    in   1   VDG horizontal sync, active low
//   vdg_fs_n    in   1   VDG field sync, active low
//   e, q        out  1   CPU quadrature clocks
//   cycle_end   out  1   one-clk strobe, last clk of each E period
//   s           out  3   chip select
//   z_addr      out 16   RAM address (video or CPU)
//   vid_phase   out  1   1 while z_addr carries video address
//   mode        out  3   VDG mode bits V[2:0]
// BEHAVIOUR
//   Reset: all control bits 0, phase 0, e=q=cycle_end=0, vid_addr=0, row_cnt=0.
//   Control bank: 16 bits {TY,M1,M0,R1,R0,P,F6..F0,V2..V0} in index order V0=0 .. TY=15.
//     Write when ~cpu_rw && cpu_addr[15:5]==11'h7FE at cycle_end; bit[cpu_addr[4:1]] <= cpu_addr[0].
//     Takes effect the clk after cycle_end. Reads are ignored.
//   Clock gen: phase counts 0..DIV-1, wraps to 0. e = phase >= DIV/2.
//     q = DIV/4 <= phase < 3*DIV/4. cycle_end = (phase == DIV-1).
//   DIV is selected at each cycle_end for the next period, never mid-period:
//     R=00 -> SLOW_DIV; R=01 -> FAST_DIV unless next cpu_addr decodes to s==0, then SLOW_DIV;
//     R=1x -> FAST_DIV.
//   Chip select (combinational): 0000-7FFF 0, 8000-9FFF 1, A000-BFFF 2, C000-FEFF 3,
//     FF00-FF1F 4, FF20-FF3F 5, FF40-FFBF 7, FFC0-FFFF 6.
//   CPU translation: cpu_z = (TY && !M1) ? cpu_addr : {P, cpu_addr[14:0]}.
//   Mux: vid_phase = ~e. z_addr = vid_phase ? vid_addr : cpu_z.
//   Video counter (16 bit, wraps FFFF->0000):
//     vdg_fs_n falling edge (registered detect): vid_addr <= {F,9'b0}, line_start <= same, row_cnt <= 0.
//     vdg_da0: vid_addr++.
//     vdg_hs_n falling edge: if row_cnt == ROWS(V)-1 then row_cnt<=0, line_start<=vid_addr;
//       else row_cnt++, vid_addr<=line_start.
//     ROWS(V): 0->12, 1..2->3, 3..4->2, 5..7->1.
//     Simultaneous events, priority fs > hs > da0; lower-priority events in the same clk are dropped.
//   F/V changes mid-field affect only the next fs edge (F) or the next hs edge (V).
//   Reset mid-cycle: outputs return to reset values asynchronously; restart at phase 0, slow rate.
// CONFIGURATION
//   SAM_FASTCLK_EN defined: rate selection as above.
//   Undefined: DIV always SLOW_DIV; R1/R0 are still writable and stored but ignored.
// TESTING
//   Release reset, idle -> e period 16 clk, q leads e by 4 clk, cycle_end every 16 clk.
//   Write FFD9 (R1=1) with SAM_FASTCLK_EN -> period 8 clk from the next cycle_end.
//     Without the macro -> stays 16.
//   R=01, cpu_addr alternating 1000/A000 -> periods alternate 16/8.
//   Write FFC7,FFCB (F=5), pulse fs_n -> vid_addr=0A00; 32 da0 pulses -> 0A20.
//     Next hs (V=0) -> back to 0A00.
//   V=5 (FFC1,FFC5): each hs keeps vid_addr advancing. Same-clk fs+da0 -> vid_addr={F,9'b0} exactly.
//   TY=1,M=00: cpu_addr 9000 -> z_addr 9000. TY=0,P=1: cpu_addr 1234 -> z_addr 9234, s=0.
//     FF50 -> s=7.

Source files
------------

// File: rtl/sam_ctl_gen2.sv
// sam_ctl_gen2: CoCo SAM clock, control-register and RAM address controller.
// Latency: chip select and z_addr are combinational; control writes land one clk after cycle_end.
// Backpressure: none; the CPU bus is paced by e/q and VDG strobes are consumed every clk.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   cpu_addr, cpu_rw      CPU address and R/W (1 = read)
//   vdg_da0/hs_n/fs_n     VDG byte-fetch pulse, horizontal and field sync (active low)
//   e, q, cycle_end       CPU quadrature clocks and last-clk-of-E-period strobe
//   s                     chip select
//   z_addr, vid_phase     RAM address and video-slot flag (high while e is low)
//   mode                  VDG mode bits V[2:0]
//
// Build option: SAM_FASTCLK_EN enables the R1/R0 MPU rate selection. Without it
// every E period is SLOW_DIV clks and R1/R0 are stored but have no effect.
module sam_ctl_gen2 #(
  parameter int SLOW_DIV = 16,
  parameter int FAST_DIV = 8,
  parameter int OFFSET_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        vdg_da0,
  input  logic        vdg_hs_n,
  input  logic        vdg_fs_n,
  output logic        e,
  output logic        q,
  output logic        cycle_end,
  output logic [2:0]  s,
  output logic [15:0] z_addr,
  output logic        vid_phase,
  output logic [2:0]  mode
);

  localparam int PW = $clog2((SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV);

  localparam logic [PW-1:0] S_LAST = PW'(SLOW_DIV - 1);
  localparam logic [PW-1:0] S_HALF = PW'(SLOW_DIV / 2);
  localparam logic [PW-1:0] S_Q1   = PW'(SLOW_DIV / 4);
  localparam logic [PW-1:0] S_Q3   = PW'(3 * SLOW_DIV / 4);
  localparam logic [PW-1:0] F_LAST = PW'(FAST_DIV - 1);
  localparam logic [PW-1:0] F_HALF = PW'(FAST_DIV / 2);
  localparam logic [PW-1:0] F_Q1   = PW'(FAST_DIV / 4);
  localparam logic [PW-1:0] F_Q3   = PW'(3 * FAST_DIV / 4);

  // Control bank, index order {TY,M1,M0,R1,R0,P,F6..F0,V2..V0}.
  logic [15:0]         ctrl;
  logic [2:0]          v;
  logic [OFFSET_W-1:0] f;
  logic                p;
  logic [1:0]          r;
  logic [1:0]          m;
  logic                ty;

  assign v  = ctrl[2:0];
  assign f  = ctrl[3 +: OFFSET_W];
  assign p  = ctrl[10];
  assign r  = ctrl[12:11];
  assign m  = ctrl[14:13];
  assign ty = ctrl[15];

  // Clock generator state: position within the E period and the rate of the
  // current period (latched only at cycle_end so a period is never cut short).
  logic [PW-1:0] phase;
  logic          fast;
  logic          next_fast;

  always_comb begin
    e         = 1'b0;
    q         = 1'b0;
    cycle_end = 1'b0;
    if (fast) begin
      e         = (phase >= F_HALF);
      q         = (phase >= F_Q1) && (phase < F_Q3);
      cycle_end = (phase == F_LAST);
    end else begin
      e         = (phase >= S_HALF);
      q         = (phase >= S_Q1) && (phase < S_Q3);
      cycle_end = (phase == S_LAST);
    end
  end

  // Chip select decode.
  always_comb begin
    s = 3'd0;
    if (!cpu_addr[15]) begin
      s = 3'd0;
    end else if (cpu_addr[15:13] == 3'b100) begin
      s = 3'd1;
    end else if (cpu_addr[15:13] == 3'b101) begin
      s = 3'd2;
    end else if (cpu_addr[15:8] != 8'hFF) begin
      s = 3'd3;
    end else begin
      case (cpu_addr[7:5])
        3'b000:  s = 3'd4;
        3'b001:  s = 3'd5;
        3'b110,
        3'b111:  s = 3'd6;
        default: s = 3'd7;
      endcase
    end
  end

`ifdef SAM_FASTCLK_EN
  // R=01 is the "address dependent" rate: RAM at s==0 must run slow.
  always_comb begin
    next_fast = 1'b0;
    case (r)
      2'b00:   next_fast = 1'b0;
      2'b01:   next_fast = (s != 3'd0);
      default: next_fast = 1'b1;
    endcase
  end
`else
  logic unused_rate;
  assign unused_rate = ^r;
  assign next_fast   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      fast  <= 1'b0;
    end else if (cycle_end) begin
      phase <= '0;
      fast  <= next_fast;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  // Control bank writes: the address selects the bit, A0 is the value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
    end else if (cycle_end && !cpu_rw && (cpu_addr[15:5] == 11'h7FE)) begin
      ctrl[cpu_addr[4:1]] <= cpu_addr[0];
    end
  end

  // Video address counter.
  logic        fs_q;
  logic        hs_q;
  logic        fs_fall;
  logic        hs_fall;
  logic [15:0] vid_addr;
  logic [15:0] line_start;
  logic [3:0]  row_cnt;
  logic [3:0]  rows_m1;
  logic [15:0] base;

  assign fs_fall = fs_q & ~vdg_fs_n;
  assign hs_fall = hs_q & ~vdg_hs_n;
  assign base    = 16'({f, 9'b0});

  // Rows per character line minus one, by VDG mode.
  always_comb begin
    rows_m1 = 4'd0;
    case (v)
      3'd0:       rows_m1 = 4'd11;
      3'd1, 3'd2: rows_m1 = 4'd2;
      3'd3, 3'd4: rows_m1 = 4'd1;
      default:    rows_m1 = 4'd0;
    endcase
  end

  // Sync inputs idle high, so the edge registers reset high to avoid a
  // spurious falling edge straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_q <= 1'b1;
      hs_q <= 1'b1;
    end else begin
      fs_q <= vdg_fs_n;
      hs_q <= vdg_hs_n;
    end
  end

  // Priority fs > hs > da0; a lower-priority event in the same clk is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_addr   <= '0;
      line_start <= '0;
      row_cnt    <= '0;
    end else if (fs_fall) begin
      vid_addr   <= base;
      line_start <= base;
      row_cnt    <= '0;
    end else if (hs_fall) begin
      if (row_cnt == rows_m1) begin
        row_cnt    <= '0;
        line_start <= vid_addr;
      end else begin
        row_cnt  <= row_cnt + 1'b1;
        vid_addr <= line_start;
      end
    end else if (vdg_da0) begin
      vid_addr <= vid_addr + 1'b1;
    end
  end

  // Address translation and RAM bus mux.
  logic [15:0] cpu_z;

  assign cpu_z     = (ty && !m[1]) ? cpu_addr : {p, cpu_addr[14:0]};
  assign vid_phase = ~e;
  assign z_addr    = vid_phase ? vid_addr : cpu_z;
  assign mode      = v;

endmodule

// File: tb/tb_sam_ctl_gen2.sv
// Directed bench for sam_ctl_gen2: clock periods, control writes, video counter,
// address translation and chip select, with hand-computed expectations.
module tb_sam_ctl_gen2;

`ifdef SAM_FASTCLK_EN
  localparam int EXP_FAST = 8;
`else
  localparam int EXP_FAST = 16;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic        vdg_da0;
  logic        vdg_hs_n;
  logic        vdg_fs_n;
  logic        e, q, cycle_end;
  logic [2:0]  s;
  logic [15:0] z_addr;
  logic        vid_phase;
  logic [2:0]  mode;

  int n_vec = 0;
  int n_err = 0;
  int per;

  sam_ctl_gen2 dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_rw    (cpu_rw),
    .vdg_da0   (vdg_da0),
    .vdg_hs_n  (vdg_hs_n),
    .vdg_fs_n  (vdg_fs_n),
    .e         (e),
    .q         (q),
    .cycle_end (cycle_end),
    .s         (s),
    .z_addr    (z_addr),
    .vid_phase (vid_phase),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired, observed none expected event", tag);
  endtask

  // Advance to the next negedge at which cycle_end is high.
  task automatic wait_ce();
    int k;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      if (cycle_end) break;
    end
    if (k == 64) timeout("wait_ce");
  endtask

  task automatic wait_e(input logic want);
    int k;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      if (e === want) break;
    end
    if (k == 64) timeout("wait_e");
  endtask

  // From a cycle_end negedge: let the selection edge pass, present next_addr,
  // then count clks to the following cycle_end.
  task automatic measure(input logic [15:0] next_addr, output int period);
    int k;
    @(posedge clk);
    #1 cpu_addr = next_addr;
    period = 0;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      period++;
      if (cycle_end) break;
    end
    if (k == 64) timeout("measure");
  endtask

  // Control bank write, captured at the next cycle_end.
  task automatic wr(input logic [15:0] a);
    cpu_addr = a;
    cpu_rw   = 1'b0;
    wait_ce();
    @(posedge clk);
    #1;
    cpu_rw   = 1'b1;
    cpu_addr = 16'h1000;
  endtask

  task automatic pulse(input logic fs, input logic hs, input logic da);
    @(negedge clk);
    vdg_fs_n = ~fs;
    vdg_hs_n = ~hs;
    vdg_da0  = da;
    @(negedge clk);
    vdg_fs_n = 1'b1;
    vdg_hs_n = 1'b1;
    vdg_da0  = 1'b0;
  endtask

  task automatic vid_chk(input string tag, input logic [15:0] exp);
    wait_e(1'b0);
    chk(tag, z_addr, exp);
  endtask

  logic [15:0] sa [9] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hBFFF, 16'hC000,
                          16'hFEFF, 16'hFF20, 16'hFFBF, 16'hFFC0};
  logic [2:0]  se [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd5, 3'd7, 3'd6};

  initial begin
    int qk, ek;
    reset    = 1'b1;
    cpu_addr = 16'h0000;
    cpu_rw   = 1'b1;
    vdg_da0  = 1'b0;
    vdg_hs_n = 1'b1;
    vdg_fs_n = 1'b1;

    #1;
    chk("rst_e", {15'd0, e}, 16'd0);
    chk("rst_q", {15'd0, q}, 16'd0);
    chk("rst_ce", {15'd0, cycle_end}, 16'd0);
    chk("rst_z", z_addr, 16'h0000);
    chk("rst_vp", {15'd0, vid_phase}, 16'd1);
    chk("rst_mode", {13'd0, mode}, 16'd0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle slow rate and q/e quadrature.
    wait_ce();
    measure(16'h1000, per);
    chk("idle_period", 16'(per), 16'd16);
    qk = 0;
    ek = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (q && qk == 0) qk = k;
      if (e && ek == 0) ek = k;
    end
    chk("q_rise", 16'(qk), 16'd5);
    chk("e_rise", 16'(ek), 16'd9);

    // R1=1: fast from the period selected after the write lands.
    wr(16'hFFD9);
    wait_ce();
    measure(16'h1000, per);
    chk("r1_period", 16'(per), 16'(EXP_FAST));

    // R=01: rate follows the address presented at cycle_end.
    wr(16'hFFD8);
    wr(16'hFFD7);
    cpu_addr = 16'h1000;
    wait_ce();
    measure(16'hA000, per);
    chk("r01_ram", 16'(per), 16'd16);
    measure(16'h1000, per);
    chk("r01_rom", 16'(per), 16'(EXP_FAST));
    measure(16'hA000, per);
    chk("r01_ram2", 16'(per), 16'd16);

    // Video counter, F=5, V=0.
    wr(16'hFFC7);
    wr(16'hFFCB);
    chk("mode_v0", {13'd0, mode}, 16'd0);
    pulse(1'b1, 1'b0, 1'b0);
    vid_chk("fs_base", 16'h0A00);
    repeat (32) pulse(1'b0, 1'b0, 1'b1);
    vid_chk("da0_x32", 16'h0A20);
    pulse(1'b0, 1'b1, 1'b0);
    vid_chk("hs_repeat", 16'h0A00);

    // V=5: one row per line, hs never rewinds.
    wr(16'hFFC1);
    wr(16'hFFC5);
    chk("mode_v5", {13'd0, mode}, 16'd5);
    cpu_addr = 16'hFFC3;
    cpu_rw   = 1'b1;
    wait_ce();
    @(negedge clk);
    chk("read_ignored", {13'd0, mode}, 16'd5);
    cpu_addr = 16'h1000;
    pulse(1'b1, 1'b0, 1'b0);
    repeat (16) pulse(1'b0, 1'b0, 1'b1);
    vid_chk("v5_da0", 16'h0A10);
    pulse(1'b0, 1'b1, 1'b0);
    vid_chk("v5_hs", 16'h0A10);
    repeat (4) pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b1);
    vid_chk("hs_beats_da0", 16'h0A14);
    pulse(1'b1, 1'b0, 1'b1);
    vid_chk("fs_beats_da0", 16'h0A00);

    // CPU address translation.
    wr(16'hFFDF);
    cpu_addr = 16'h9000;
    wait_e(1'b1);
    chk("ty_z", z_addr, 16'h9000);
    chk("ty_s", {13'd0, s}, 16'd1);
    wr(16'hFFDE);
    wr(16'hFFD5);
    cpu_addr = 16'h1234;
    wait_e(1'b1);
    chk("p1_z", z_addr, 16'h9234);
    chk("p1_s", {13'd0, s}, 16'd0);
    cpu_addr = 16'hFF50;
    #1;
    chk("s_ff50", {13'd0, s}, 16'd7);

    for (int i = 0; i < 9; i++) begin
      cpu_addr = sa[i];
      #1;
      chk($sformatf("s_%h", sa[i]), {13'd0, s}, {13'd0, se[i]});
    end
    cpu_addr = 16'h1000;

    // Asynchronous reset in the middle of an E-high phase.
    wait_e(1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_e", {15'd0, e}, 16'd0);
    chk("mid_rst_q", {15'd0, q}, 16'd0);
    chk("mid_rst_z", z_addr, 16'h0000);
    chk("mid_rst_mode", {13'd0, mode}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_ce();
    measure(16'h1000, per);
    chk("post_rst_period", 16'(per), 16'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
